game_flow_controller: RTL

Parametrised game-flow state machine for the Frogger top level. It owns the IDLE/RUNNING cycle and adds several features:
- configurable life count, a respawn delay after each death, and a level counter with a win condition;
- a GAME_OVER state and a restart path;
- a per-lane direction mask of configurable width reloaded from the LFSR.

It sits between the debounced switches and collision/level-up sources, and feeds Character_Control, Obstacles_Movement and the LED outputs.

---
 rtl/game_flow_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller: Frogger game-flow FSM (idle/run/die/over/win),
// lives, level, respawn pulse and LFSR-fed lane direction mask.
//
// Ports:
//   i_Clk, i_Rst_L        clock, synchronous active-low reset
//   i_Start               debounced start level (rising edge used)
//   i_Has_Collided        frog/car collision level
//   i_Level_Up            far-bank reached, 1-cycle pulse
//   i_LFSR_Data           random lane bits for the reverse mask
//   o_State               IDLE=0 RUNNING=1 DYING=2 GAME_OVER=3 WIN=4
//   o_Game_Active         state is RUNNING
//   o_Respawn             1-cycle pulse, frog back to start
//   o_Lives               thermometer of remaining lives
//   o_Level               current level
//   o_Lane_Reverse        per-lane direction mask
//   o_Game_Over, o_Win    state decodes
module game_flow_controller #(
    parameter int NUM_LIVES     = 4,
    parameter int NUM_LANES     = 4,
    parameter int RESPAWN_DELAY = 25_000_000,
    parameter int MAX_LEVEL     = 9,
    parameter int LEVEL_W       = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Start,
    input  logic                 i_Has_Collided,
    input  logic                 i_Level_Up,
    input  logic [NUM_LANES-1:0] i_LFSR_Data,
    output logic [2:0]           o_State,
    output logic                 o_Game_Active,
    output logic                 o_Respawn,
    output logic [NUM_LIVES-1:0] o_Lives,
    output logic [LEVEL_W-1:0]   o_Level,
    output logic [NUM_LANES-1:0] o_Lane_Reverse,
    output logic                 o_Game_Over,
    output logic                 o_Win
);

    localparam int CNT_W = $clog2(RESPAWN_DELAY) + 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUNNING   = 3'd1;
    localparam logic [2:0] ST_DYING     = 3'd2;
    localparam logic [2:0] ST_GAME_OVER = 3'd3;
    localparam logic [2:0] ST_WIN       = 3'd4;

    localparam logic [CNT_W-1:0] DELAY_LOAD =
        CNT_W'(RESPAWN_DELAY - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX =
        LEVEL_W'(MAX_LEVEL);

    logic [2:0]           r_State;
    logic                 r_Start_Prev;
    logic                 r_Respawn;
    logic [NUM_LIVES-1:0] r_Lives;
    logic [LEVEL_W-1:0]   r_Level;
    logic [NUM_LANES-1:0] r_Lane;
    logic [CNT_W-1:0]     r_Count;

    logic                 start_rise;
    logic                 level_accept;
    logic                 lane_load;
    logic [NUM_LIVES-1:0] lives_shift;
    logic [LEVEL_W-1:0]   level_inc;

    assign start_rise   = i_Start & ~r_Start_Prev;
    // collision wins over level-up in the same cycle
    assign level_accept = (r_State == ST_RUNNING) &
                          i_Level_Up & ~i_Has_Collided;
    assign lane_load    = (r_Lane == '0) | level_accept;
    assign lives_shift  = r_Lives >> 1;
    assign level_inc    = r_Level + 1'b1;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State      <= ST_IDLE;
            r_Start_Prev <= 1'b1;
            r_Respawn    <= 1'b0;
            r_Lives      <= '1;
            r_Level      <= '0;
            r_Lane       <= '0;
            r_Count      <= '0;
        end else begin
            r_Start_Prev <= i_Start;
            r_Respawn    <= 1'b0;
            if (lane_load)
                r_Lane <= i_LFSR_Data;

            case (r_State)
                ST_IDLE: begin
                    if (start_rise)
                        r_State <= ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (i_Has_Collided) begin
                        r_Lives <= lives_shift;
                        if (lives_shift == '0) begin
                            r_State <= ST_GAME_OVER;
                        end else begin
                            r_State <= ST_DYING;
                            r_Count <= DELAY_LOAD;
                        end
                    end else if (i_Level_Up) begin
                        r_Level <= level_inc;
                        if (level_inc == LEVEL_MAX)
                            r_State <= ST_WIN;
                        else
                            r_Respawn <= 1'b1;
                    end
                end
                ST_DYING: begin
                    if (r_Count == '0) begin
                        r_State   <= ST_IDLE;
                        r_Respawn <= 1'b1;
                    end else begin
                        r_Count <= r_Count - 1'b1;
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    if (start_rise) begin
                        r_State   <= ST_IDLE;
                        r_Lives   <= '1;
                        r_Level   <= '0;
                        r_Respawn <= 1'b1;
                    end
                end
                default: r_State <= ST_IDLE;
            endcase
        end
    end

    assign o_State        = r_State;
    assign o_Game_Active  = (r_State == ST_RUNNING);
    assign o_Game_Over    = (r_State == ST_GAME_OVER);
    assign o_Win          = (r_State == ST_WIN);
    assign o_Respawn      = r_Respawn;
    assign o_Lives        = r_Lives;
    assign o_Level        = r_Level;
    assign o_Lane_Reverse = r_Lane;

endmodule
